// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package sys_array_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN,
    FIN
  } state_t;

  // Accept-to-m_valid latency: lane stage, input skew, array pipe, output register.
  function automatic int unsigned ctrl_lat(input int unsigned rows, input int unsigned pipe_lat);
    return rows + pipe_lat + 1;
  endfunction

endpackage

// File: rtl/sys_array_skew.sv
// Fixed-depth delay line used for per-lane input skew and output de-skew.
module sys_array_skew #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sys_array_ctrl.sv
// Job sequencer for the systolic array: weight load, skewed input feed, aligned result output.
module sys_array_ctrl
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W_W  = 4,
  parameter int unsigned ARRAY_W_L  = 4,
  parameter int unsigned PIPE_LAT   = 4,
  parameter int unsigned MAX_VEC    = 256
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [$clog2(MAX_VEC+1)-1:0]                  num_vec,
  input  logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]     weight_in,
  output logic                                          busy,
  output logic                                          done,
  input  logic                                          s_valid,
  input  logic [ARRAY_W_W*DATA_WIDTH-1:0]               s_data,
  output logic                                          s_ready,
  output logic                                          m_valid,
  output logic [ARRAY_W_W*2*DATA_WIDTH-1:0]             m_data,
  output logic                                          m_last,
  output logic                                          arr_weights_load,
  output logic [ARRAY_W_W*ARRAY_W_L*DATA_WIDTH-1:0]     arr_weight_data,
  output logic [ARRAY_W_W*DATA_WIDTH-1:0]               arr_input_data,
  input  logic [ARRAY_W_W*2*DATA_WIDTH-1:0]             arr_output_data
);

  localparam int unsigned R   = ARRAY_W_W;
  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned OW  = 2 * DATA_WIDTH;
  localparam int unsigned VW  = $clog2(MAX_VEC + 1);
  localparam int unsigned LAT = ctrl_lat(ARRAY_W_W, PIPE_LAT);

  state_t                     state;
  logic [VW-1:0]              cnt;
  logic [R*ARRAY_W_L*DW-1:0]  wreg;
  logic [LAT-1:0]             vtag;
  logic [LAT-1:0]             ltag;
  logic [R*DW-1:0]            stage0;
  logic [R*OW-1:0]            deskew;
  logic                       accept;
  logic                       last_accept;

  assign s_ready         = (state == FEED);
  assign accept          = s_valid & s_ready;
  assign last_accept     = accept & (cnt == VW'(1));
  assign arr_weight_data = wreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      wreg             <= '0;
      arr_weights_load <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      arr_weights_load <= 1'b0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wreg             <= weight_in;
            cnt              <= num_vec;
            arr_weights_load <= 1'b1;
            busy             <= 1'b1;
            state            <= LOAD;
          end
        end
        LOAD: state <= (cnt == '0) ? DRAIN : FEED;
        FEED: begin
          if (s_valid) begin
            cnt <= cnt - VW'(1);
            if (cnt == VW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // m_valid is vtag's last stage, so FIN lands two cycles after m_last.
          if (vtag == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vtag   <= '0;
      ltag   <= '0;
      stage0 <= '0;
      m_data <= '0;
    end else begin
      vtag   <= {vtag[LAT-2:0], accept};
      ltag   <= {ltag[LAT-2:0], last_accept};
      // Bubbles and drain cycles push zeros so the array never sees stale data.
      stage0 <= accept ? s_data : '0;
      m_data <= deskew;
    end
  end

  assign m_valid = vtag[LAT-1];
  assign m_last  = ltag[LAT-1];

  for (genvar r = 0; r < R; r++) begin : g_lane
    if (r == 0) begin : g_in_direct
      assign arr_input_data[r*DW +: DW] = stage0[r*DW +: DW];
    end else begin : g_in_skew
      sys_array_skew #(
        .WIDTH (DW),
        .DEPTH (r)
      ) u_skew_in (
        .clk   (clk),
        .reset (reset),
        .din   (stage0[r*DW +: DW]),
        .dout  (arr_input_data[r*DW +: DW])
      );
    end

    if (r == R - 1) begin : g_out_direct
      assign deskew[r*OW +: OW] = arr_output_data[r*OW +: OW];
    end else begin : g_out_skew
      sys_array_skew #(
        .WIDTH (OW),
        .DEPTH (R - 1 - r)
      ) u_skew_out (
        .clk   (clk),
        .reset (reset),
        .din   (arr_output_data[r*OW +: OW]),
        .dout  (deskew[r*OW +: OW])
      );
    end
  end

endmodule
